// File: rtl/ir_decode_stage_pkg.sv
// Shared instruction-format codes, RV32 opcodes and the decoded-entry record for ir_decode_stage.
// Define IR_DECODE_ILLEGAL_EN to carry an illegal-instruction flag in each decoded entry.
package ir_decode_stage_pkg;

  typedef enum logic [2:0] {
    INSTR_R = 3'd0,
    INSTR_I = 3'd1,
    INSTR_S = 3'd2,
    INSTR_B = 3'd3,
    INSTR_U = 3'd4,
    INSTR_J = 3'd5
  } instr_type_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_IR = 32'h0000_0013;

  typedef struct packed {
    instr_type_e instr_type;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
`ifdef IR_DECODE_ILLEGAL_EN
    logic        illegal;
`endif
  } dec_t;

  // Field extraction is format-independent; the format code only steers the immediate generator.
  function automatic dec_t decode_fields(input logic [31:0] ir, input instr_type_e instr_type);
    dec_t d;
    d            = '0;
    d.instr_type = instr_type;
    d.rd         = ir[11:7];
    d.rs1        = ir[19:15];
    d.rs2        = ir[24:20];
    d.funct3     = ir[14:12];
    d.funct7     = ir[31:25];
    return d;
  endfunction

endpackage

// File: rtl/ir_decode_stage_classify.sv
// Combinational opcode -> instruction format classifier.
// With IR_DECODE_ILLEGAL_EN defined it also flags unmapped opcodes and the all-zero word.
module ir_opcode_classify
  import ir_decode_stage_pkg::*;
(
  input  logic [6:0]  opcode,
`ifdef IR_DECODE_ILLEGAL_EN
  input  logic        ir_zero,
  output logic        illegal,
`endif
  output instr_type_e instr_type
);

  // Every mapped opcode ends in 2'b11, so a compressed/invalid low pair lands in default.
  always_comb begin
    instr_type = INSTR_I;
`ifdef IR_DECODE_ILLEGAL_EN
    illegal    = ir_zero;
`endif
    case (opcode)
      OP_LUI, OP_AUIPC:                              instr_type = INSTR_U;
      OP_JAL:                                        instr_type = INSTR_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: instr_type = INSTR_I;
      OP_BRANCH:                                     instr_type = INSTR_B;
      OP_STORE:                                      instr_type = INSTR_S;
      OP_REG:                                        instr_type = INSTR_R;
      default: begin
        instr_type = INSTR_I;
`ifdef IR_DECODE_ILLEGAL_EN
        illegal    = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/ir_decode_stage.sv
// Instruction register / decode stage with a 2-entry skid buffer (main drives outputs, skid absorbs one beat).
// Define IR_DECODE_ILLEGAL_EN to add the registered d_illegal output.
module ir_decode_stage
  import ir_decode_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [31:0]     f_ir,
  input  logic [XLEN-1:0] f_pc,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [31:0]     d_ir,
  output logic [XLEN-1:0] d_pc,
  output logic [2:0]      d_instr_type,
  output logic [4:0]      d_rd,
  output logic [4:0]      d_rs1,
  output logic [4:0]      d_rs2,
  output logic [2:0]      d_funct3,
`ifdef IR_DECODE_ILLEGAL_EN
  output logic            d_illegal,
`endif
  output logic [6:0]      d_funct7
);

  logic            main_valid_reg, main_valid_next;
  logic            skid_valid_reg, skid_valid_next;
  logic [31:0]     main_ir_reg, skid_ir_reg;
  logic [XLEN-1:0] main_pc_reg, skid_pc_reg;
  dec_t            main_dec_reg, skid_dec_reg;

  instr_type_e     f_type;
  dec_t            f_dec;
  logic            accept, xfer;
  logic            main_from_fetch, main_from_skid, skid_from_fetch;

`ifdef IR_DECODE_ILLEGAL_EN
  logic            f_illegal;
`endif

  ir_opcode_classify u_classify (
    .opcode     (f_ir[6:0]),
`ifdef IR_DECODE_ILLEGAL_EN
    .ir_zero    (f_ir == 32'h0),
    .illegal    (f_illegal),
`endif
    .instr_type (f_type)
  );

  always_comb begin
    f_dec = decode_fields(f_ir, f_type);
`ifdef IR_DECODE_ILLEGAL_EN
    f_dec.illegal = f_illegal;
`endif
  end

  assign f_ready = !skid_valid_reg;
  assign accept  = f_valid && f_ready;
  assign xfer    = main_valid_reg && d_ready;

  // f_ready is low whenever skid is full, so a skid->main move never coincides with an accept.
  always_comb begin
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    main_from_fetch = 1'b0;
    main_from_skid  = 1'b0;
    skid_from_fetch = 1'b0;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (xfer && skid_valid_reg) begin
      main_from_skid  = 1'b1;
      skid_valid_next = 1'b0;
    end else if (xfer || !main_valid_reg) begin
      main_from_fetch = accept;
      main_valid_next = accept;
    end else if (accept) begin
      skid_from_fetch = 1'b1;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_ir_reg    <= NOP_IR;
      main_pc_reg    <= RESET_PC;
      main_dec_reg   <= decode_fields(NOP_IR, INSTR_I);
      skid_ir_reg    <= NOP_IR;
      skid_pc_reg    <= RESET_PC;
      skid_dec_reg   <= decode_fields(NOP_IR, INSTR_I);
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      if (main_from_skid) begin
        main_ir_reg  <= skid_ir_reg;
        main_pc_reg  <= skid_pc_reg;
        main_dec_reg <= skid_dec_reg;
      end else if (main_from_fetch) begin
        main_ir_reg  <= f_ir;
        main_pc_reg  <= f_pc;
        main_dec_reg <= f_dec;
      end
      if (skid_from_fetch) begin
        skid_ir_reg  <= f_ir;
        skid_pc_reg  <= f_pc;
        skid_dec_reg <= f_dec;
      end
    end
  end

  assign d_valid      = main_valid_reg;
  assign d_ir         = main_ir_reg;
  assign d_pc         = main_pc_reg;
  assign d_instr_type = main_dec_reg.instr_type;
  assign d_rd         = main_dec_reg.rd;
  assign d_rs1        = main_dec_reg.rs1;
  assign d_rs2        = main_dec_reg.rs2;
  assign d_funct3     = main_dec_reg.funct3;
  assign d_funct7     = main_dec_reg.funct7;
`ifdef IR_DECODE_ILLEGAL_EN
  assign d_illegal    = main_dec_reg.illegal;
`endif

endmodule

// File: tb/tb_ir_decode_stage.sv
// Self-checking bench for ir_decode_stage: directed scenarios plus random traffic against a 2-deep FIFO model.
// Build with IR_DECODE_ILLEGAL_EN defined to also check d_illegal.
module tb_ir_decode_stage;

  localparam int              XLEN = 32;
  localparam logic [XLEN-1:0] RPC  = 32'h0000_0400;

  logic            clk = 1'b0;
  logic            rst_n, flush, f_valid, d_ready;
  logic [31:0]     f_ir;
  logic [XLEN-1:0] f_pc;
  logic            f_ready, d_valid;
  logic [31:0]     d_ir;
  logic [XLEN-1:0] d_pc;
  logic [2:0]      d_instr_type, d_funct3;
  logic [4:0]      d_rd, d_rs1, d_rs2;
  logic [6:0]      d_funct7;
`ifdef IR_DECODE_ILLEGAL_EN
  logic            d_illegal;
`endif

  ir_decode_stage #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .f_valid      (f_valid),
    .f_ready      (f_ready),
    .f_ir         (f_ir),
    .f_pc         (f_pc),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_ir         (d_ir),
    .d_pc         (d_pc),
    .d_instr_type (d_instr_type),
    .d_rd         (d_rd),
    .d_rs1        (d_rs1),
    .d_rs2        (d_rs2),
    .d_funct3     (d_funct3),
`ifdef IR_DECODE_ILLEGAL_EN
    .d_illegal    (d_illegal),
`endif
    .d_funct7     (d_funct7)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: the stage is a 2-deep FIFO; the head is what d_* shows.
  logic [31:0]     ir_q[$];
  logic [XLEN-1:0] pc_q[$];
  bit              just_reset;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit known_opcode(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
      7'b0001111, 7'b1110011, 7'b1100011, 7'b0100011, 7'b0110011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_type(input logic [31:0] ir);
    case (ir[6:0])
      7'b0110111, 7'b0010111: return 3'd4;
      7'b1101111:             return 3'd5;
      7'b1100011:             return 3'd3;
      7'b0100011:             return 3'd2;
      7'b0110011:             return 3'd0;
      default:                return 3'd1;
    endcase
  endfunction

  task automatic check_outputs();
    logic [31:0] e;
    check_eq("f_ready", {31'b0, f_ready}, {31'b0, ir_q.size() < 2});
    check_eq("d_valid", {31'b0, d_valid}, {31'b0, ir_q.size() > 0});
    if (ir_q.size() > 0) begin
      e = ir_q[0];
      check_eq("d_ir", d_ir, e);
      check_eq("d_pc", d_pc, pc_q[0]);
      check_eq("d_instr_type", {29'b0, d_instr_type}, {29'b0, exp_type(e)});
      check_eq("d_rd", {27'b0, d_rd}, {27'b0, e[11:7]});
      check_eq("d_rs1", {27'b0, d_rs1}, {27'b0, e[19:15]});
      check_eq("d_rs2", {27'b0, d_rs2}, {27'b0, e[24:20]});
      check_eq("d_funct3", {29'b0, d_funct3}, {29'b0, e[14:12]});
      check_eq("d_funct7", {25'b0, d_funct7}, {25'b0, e[31:25]});
`ifdef IR_DECODE_ILLEGAL_EN
      check_eq("d_illegal", {31'b0, d_illegal},
               {31'b0, (e == 32'h0) || (e[1:0] != 2'b11) || !known_opcode(e[6:0])});
`endif
    end
    if (just_reset) begin
      check_eq("rst_d_ir", d_ir, 32'h0000_0013);
      check_eq("rst_d_pc", d_pc, RPC);
      check_eq("rst_d_instr_type", {29'b0, d_instr_type}, 32'd1);
      check_eq("rst_d_rd", {27'b0, d_rd}, 32'd0);
    end
  endtask

  // One clock: check outputs at negedge, drive inputs, then advance the model at posedge.
  task automatic cycle(input logic rst, input logic v, input logic [31:0] ir,
                       input logic [XLEN-1:0] pc, input logic dr, input logic fl);
    bit acc, xf;
    @(negedge clk);
    check_outputs();
    rst_n = rst; f_valid = v; f_ir = ir; f_pc = pc; d_ready = dr; flush = fl;
    @(posedge clk);
    if (!rst) begin
      ir_q.delete(); pc_q.delete(); just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (fl) begin
        ir_q.delete(); pc_q.delete();
      end else begin
        acc = v && (ir_q.size() < 2);
        xf  = (ir_q.size() > 0) && dr;
        if (xf) begin
          void'(ir_q.pop_front()); void'(pc_q.pop_front());
        end
        if (acc) begin
          ir_q.push_back(ir); pc_q.push_back(pc);
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0]  ops[11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                             7'b0010011, 7'b0001111, 7'b1110011, 7'b1100011, 7'b0100011,
                             7'b0110011};
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 15);
    if (sel < 11)       return {r[31:7], ops[sel]};
    else if (sel < 14)  return r;
    else if (sel == 14) return 32'h0;
    else                return 32'h0000_0013;
  endfunction

  logic [31:0] stream[8] = '{32'h0020A223, 32'h00208463, 32'h123450B7, 32'h008000EF,
                             32'h002081B3, 32'h00012083, 32'h40208133, 32'h00000073};
  logic [31:0] odd_words[3] = '{32'h0000007F, 32'h00000000, 32'h00000013};

  initial begin
    rst_n = 1'b0; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0; f_ir = '0; f_pc = '0;
    just_reset = 1'b0;
    repeat (2) @(posedge clk);
    cycle(1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);

    // addi x1,x0,5
    cycle(1'b1, 1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, '0, 1'b1, 1'b0);

    // back-to-back stream
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, stream[i], 32'(4 * i), 1'b1, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 32'h0, '0, 1'b1, 1'b0);

    // backpressure: third beat held until accepted
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, stream[i], 32'(32'h100 + 4 * i), 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b1, stream[2], 32'h108, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 32'h0, '0, 1'b1, 1'b0);

    // flush with main+skid full and a beat offered
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, stream[3 + i], 32'(32'h200 + 4 * i), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, stream[5], 32'h208, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, 32'h0, '0, 1'b1, 1'b0);

    // reset mid-stream with skid full
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, stream[6 + (i % 2)], 32'(32'h300 + 4 * i), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, stream[0], 32'h30C, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, '0, 1'b1, 1'b0);

    // illegal / boundary words
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, odd_words[i], 32'(32'h400 + 4 * i), 1'b1, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 32'h0, '0, 1'b1, 1'b0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 3) != 0),
            rand_ir(),
            XLEN'($urandom),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 39) == 0));
    end
    cycle(1'b1, 1'b0, 32'h0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
